// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates the single register-file write port between the ALU writeback
//   path and the load-return path. ALU results wait in a small in-order FIFO.
//   Loads have priority. A streak counter forces one FIFO pop after
//   STARVE_LIMIT consecutive load grants so that queued ALU writes always drain.
//   Optional build macro: WB_ARB_BYPASS_EN. When it is defined, an ALU request
//   that arrives with the FIFO empty and no load grant writes directly, with
//   1-cycle latency. When it is not defined, every accepted ALU request is queued.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int STK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [STK_W-1:0] LIMIT_C = STK_W'(STARVE_LIMIT);

  localparam logic [0:0] ARB_LD        = 1'b0;
  localparam logic [0:0] ARB_ALU_FORCE = 1'b1;

  logic [ADDR_W-1:0] fifo_rd_r   [DEPTH];
  logic [DATA_W-1:0] fifo_data_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [STK_W-1:0]  streak_r;
  logic [0:0]        state_r;

  logic              fifo_empty_s;
  logic              alu_acc_s;
  logic              ld_grant_s;
  logic              pop_s;
  logic              push_s;
  logic              bypass_s;
  logic              win_s;
  logic [ADDR_W-1:0] win_rd_s;
  logic [DATA_W-1:0] win_data_s;
  logic [0:0]        state_nxt_s;
  logic [STK_W-1:0]  streak_nxt_s;
  logic [STK_W-1:0]  streak_inc_s;

  // The ALU ready signal looks only at the current occupancy, not at a same-cycle pop.
  assign alu_ready    = !reset && (count_r < DEPTH_C);
  assign ld_ready     = !reset && (state_r == ARB_LD);
  assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
  assign alu_acc_s    = alu_valid && alu_ready;
  assign ld_grant_s   = ld_valid && ld_ready;
  assign push_s       = alu_acc_s && !bypass_s;
  assign streak_inc_s = streak_r + STK_W'(1);

  // Pick the single write-port winner: load first, then FIFO head, then optional bypass.
  always_comb begin
    pop_s      = 1'b0;
    bypass_s   = 1'b0;
    win_s      = 1'b0;
    win_rd_s   = fifo_rd_r[rd_ptr_r];
    win_data_s = fifo_data_r[rd_ptr_r];
    if (ld_grant_s) begin
      win_s      = 1'b1;
      win_rd_s   = ld_rd;
      win_data_s = ld_data;
    end else if (!fifo_empty_s) begin
      win_s = 1'b1;
      pop_s = 1'b1;
`ifdef WB_ARB_BYPASS_EN
    end else if (alu_acc_s) begin
      win_s      = 1'b1;
      bypass_s   = 1'b1;
      win_rd_s   = alu_rd;
      win_data_s = alu_data;
`endif
    end else begin
      win_s = 1'b0;
    end
  end

  // Starvation guard: count load grants that pass a waiting FIFO, then force one pop.
  always_comb begin
    state_nxt_s  = state_r;
    streak_nxt_s = streak_r;
    case (state_r)
      ARB_LD: begin
        if (ld_grant_s && !fifo_empty_s) begin
          streak_nxt_s = streak_inc_s;
          if (streak_inc_s >= LIMIT_C) begin
            state_nxt_s = ARB_ALU_FORCE;
          end else begin
            state_nxt_s = ARB_LD;
          end
        end else begin
          streak_nxt_s = {STK_W{1'b0}};
          state_nxt_s  = ARB_LD;
        end
      end
      ARB_ALU_FORCE: begin
        streak_nxt_s = {STK_W{1'b0}};
        state_nxt_s  = ARB_LD;
      end
      default: begin
        streak_nxt_s = {STK_W{1'b0}};
        state_nxt_s  = ARB_LD;
      end
    endcase
  end

  // FIFO payload storage; entries are only meaningful while counted, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_rd_r[wr_ptr_r]   <= alu_rd;
      fifo_data_r[wr_ptr_r] <= alu_data;
    end
  end

  // FIFO pointers, occupancy and arbiter state; reset discards queued entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      streak_r <= {STK_W{1'b0}};
      state_r  <= ARB_LD;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      streak_r <= streak_nxt_s;
      state_r  <= state_nxt_s;
    end
  end

  // Register the winner onto the write port; index and data hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en   <= 1'b0;
      wb_rd   <= {ADDR_W{1'b0}};
      wb_data <= {DATA_W{1'b0}};
    end else begin
      wb_en <= win_s;
      if (win_s) begin
        wb_rd   <= win_rd_s;
        wb_data <= win_data_s;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_regfile_wb_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 4;
  localparam int DEPTH        = 2;
  localparam int STARVE_LIMIT = 4;
`ifdef WB_ARB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  // Reference model: ALU entries waiting in order, and the number of load
  // grants that have passed a non-empty queue since the last ALU write.
  wr_t         alu_q[$];
  int          load_run = 0;
  bit          exp_en = 1'b0;
  logic [3:0]  exp_rd = 4'd0;
  logic [31:0] exp_data = 32'd0;

  int total = 0;
  int bad   = 0;
  bit obs_ar;
  bit obs_lr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check readies, advance the model, check the write port.
  task automatic cyc(input bit r, input bit av, input logic [3:0] ard, input logic [31:0] adat,
                     input bit lv, input logic [3:0] lrd, input logic [31:0] ldat,
                     output bit a_acc, output bit l_acc);
    bit  m_ar, m_lr, was_empty, wrote, bypassed;
    wr_t w;
    reset = r; alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat;
    #1;
    m_ar   = !r && (alu_q.size() < DEPTH);
    m_lr   = !r && (load_run < STARVE_LIMIT);
    obs_ar = alu_ready;
    obs_lr = ld_ready;
    chk("alu_ready", {31'd0, alu_ready}, {31'd0, m_ar});
    chk("ld_ready", {31'd0, ld_ready}, {31'd0, m_lr});
    a_acc = av && m_ar;
    l_acc = lv && m_lr;
    wrote = 1'b0; bypassed = 1'b0; w = '0;
    if (r) begin
      alu_q.delete();
      load_run = 0;
      exp_en = 1'b0; exp_rd = 4'd0; exp_data = 32'd0;
    end else begin
      was_empty = (alu_q.size() == 0);
      if (l_acc) begin
        wrote = 1'b1; w = {lrd, ldat};
        load_run = was_empty ? 0 : load_run + 1;
      end else if (!was_empty) begin
        wrote = 1'b1; w = alu_q.pop_front();
        load_run = 0;
      end else if (BYPASS && a_acc) begin
        wrote = 1'b1; bypassed = 1'b1; w = {ard, adat};
        load_run = 0;
      end else begin
        load_run = 0;
      end
      if (a_acc && !bypassed) alu_q.push_back({ard, adat});
      exp_en = wrote;
      if (wrote) begin
        exp_rd = w.rd; exp_data = w.data;
      end
    end
    @(posedge clk);
    #1;
    chk("wb_en", {31'd0, wb_en}, {31'd0, exp_en});
    chk("wb_rd", {28'd0, wb_rd}, {28'd0, exp_rd});
    chk("wb_data", wb_data, exp_data);
    @(negedge clk);
  endtask

  bit          aacc, lacc, pa, pl, rs;
  int          ai, li, lp;
  logic [3:0]  ar, lr;
  logic [31:0] ad, ldd;

  initial begin
    // Reset state.
    cyc(1'b1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, aacc, lacc);
    cyc(1'b1, 1'b1, 4'd1, 32'd1, 1'b1, 4'd2, 32'd2, aacc, lacc);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_alu_ready", {31'd0, obs_ar}, 32'd0);
    chk("rst_ld_ready", {31'd0, obs_lr}, 32'd0);

    // Single ALU write rd=3 data=0x11: t+1 with bypass, t+2 without.
    cyc(1'b0, 1'b1, 4'd3, 32'h11, 1'b0, 4'd0, 32'd0, aacc, lacc);
    chk("t1_en_t1", {31'd0, wb_en}, {31'd0, BYPASS});
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, aacc, lacc);
    chk("t1_en_t2", {31'd0, wb_en}, {31'd0, !BYPASS});
    chk("t1_rd", {28'd0, wb_rd}, 32'd3);
    chk("t1_data", wb_data, 32'h11);
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, aacc, lacc);

    // Simultaneous load and ALU requests: load first, ALU next cycle.
    cyc(1'b0, 1'b1, 4'd2, 32'hBB, 1'b1, 4'd1, 32'hAA, aacc, lacc);
    chk("t2_both_acc", {30'd0, aacc, lacc}, 32'd3);
    chk("t2_ld_rd", {28'd0, wb_rd}, 32'd1);
    chk("t2_ld_data", wb_data, 32'hAA);
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, aacc, lacc);
    chk("t2_alu_en", {31'd0, wb_en}, 32'd1);
    chk("t2_alu_rd", {28'd0, wb_rd}, 32'd2);
    chk("t2_alu_data", wb_data, 32'hBB);
    cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, aacc, lacc);

    // Loads held, three ALU requests: FIFO fills, starvation guard forces a pop.
    ai = 0; li = 0;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b0, ai < 3, 4'(5 + ai), 32'hA5 + 32'(ai), 1'b1, 4'(8 + li), 32'hD0 + 32'(li), aacc, lacc);
      if (aacc) ai++;
      if (lacc) li++;
      if (c < 5) chk("t4_load_wr", wb_data, 32'hD0 + 32'(c));
      if (c == 2) chk("t3_alu_full", {31'd0, obs_ar}, 32'd0);
      if (c == 5) begin
        chk("t4_ld_blocked", {31'd0, obs_lr}, 32'd0);
        chk("t4_force_rd", {28'd0, wb_rd}, 32'd5);
        chk("t4_force_data", wb_data, 32'hA5);
      end
      if (c == 6) begin
        chk("t4_ld_resume", {31'd0, obs_lr}, 32'd1);
        chk("t3_third_acc", {31'd0, obs_ar}, 32'd1);
        chk("t4_resume_data", wb_data, 32'hD5);
      end
    end
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, aacc, lacc);
    chk("drain_empty", 32'(alu_q.size()), 32'd0);

    // FIFO holding two entries, then reset: nothing stale may ever be written.
    cyc(1'b0, 1'b1, 4'd9, 32'hE1, 1'b1, 4'd1, 32'hF1, aacc, lacc);
    cyc(1'b0, 1'b1, 4'd10, 32'hE2, 1'b1, 4'd2, 32'hF2, aacc, lacc);
    cyc(1'b1, 1'b1, 4'd11, 32'hE3, 1'b1, 4'd3, 32'hF3, aacc, lacc);
    chk("t5_rst_en", {31'd0, wb_en}, 32'd0);
    chk("t5_rst_ready", {30'd0, obs_ar, obs_lr}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, aacc, lacc);
      chk("t5_no_stale", {31'd0, wb_en}, 32'd0);
      chk("t5_ready", {30'd0, obs_ar, obs_lr}, 32'd3);
    end

    // Random traffic in phases of heavy, medium and light load pressure.
    pa = 1'b0; pl = 1'b0;
    ar = 4'd0; ad = 32'd0; lr = 4'd0; ldd = 32'd0;
    for (int i = 0; i < 1500; i++) begin
      lp = ((i / 250) % 3 == 0) ? 95 : (((i / 250) % 3 == 1) ? 50 : 10);
      rs = ($urandom_range(0, 199) == 0);
      if (!pa) begin
        pa = ($urandom_range(0, 99) < 60);
        ar = 4'($urandom_range(0, 15));
        ad = $urandom;
      end
      if (!pl) begin
        pl = ($urandom_range(0, 99) < lp);
        lr = 4'($urandom_range(0, 15));
        ldd = $urandom;
      end
      cyc(rs, pa, ar, ad, pl, lr, ldd, aacc, lacc);
      if (aacc) pa = 1'b0;
      if (lacc) pl = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
